// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
// Holds the FSM state encoding, the default NOP word and the fetch address decoder.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } imem_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'd0;

    // Byte addresses are widened to this before decoding so any PC width up to 64 fits.
    localparam int DECODE_W = 64;

    typedef struct packed {
        logic [DECODE_W-1:0] idx;
        logic                fault;
    } fetch_decode_t;

    // No wrap-around: any set bit above the word range is a fault, as is misalignment.
    function automatic fetch_decode_t decode_fetch(input logic [DECODE_W-1:0] byte_addr,
                                                   input int unsigned         depth);
        fetch_decode_t r;
        r.idx   = byte_addr >> 2;
        r.fault = (byte_addr[1:0] != 2'b00) || (r.idx >= DECODE_W'(depth));
        return r;
    endfunction

endpackage

// File: rtl/imem_clear_seq.sv
// Post-reset clear sequencer: walks the word counter 0..DEPTH-1 while enabled.
// done_o flags the cycle that writes the last word.
module imem_clear_seq
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    output logic [$clog2(DEPTH)-1:0] cnt_o,
    output logic                     done_o
);

    localparam int CNT_W = $clog2(DEPTH);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = en_i && (cnt_q == CNT_W'(DEPTH - 1));

endmodule

// File: rtl/instr_mem_sync.sv
// Registered-read instruction memory for the IF stage, with a loader port,
// stall hold, address-fault detection and a post-reset clear pass.
module instr_mem_sync
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDR_W-1:0]        pc_addr_i,
    input  logic                     fetch_en_i,
    input  logic                     stall_i,
    output logic [DATA_W-1:0]        instr_o,
    output logic                     instr_valid_o,
    output logic                     fault_o,
    input  logic                     load_mode_i,
    input  logic                     load_we_i,
    input  logic [$clog2(DEPTH)-1:0] load_addr_i,
    input  logic [DATA_W-1:0]        load_data_i,
    output logic                     load_ack_o,
    output logic                     ready_o
);

    localparam int IDX_W = $clog2(DEPTH);

    imem_state_e      state_q, state_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic             ack_q, ack_d;
    logic             ready_q, ready_d;

    logic [IDX_W-1:0] clr_cnt;
    logic             clr_done;
    logic             clr_en;

    fetch_decode_t    dec;
    logic [IDX_W-1:0] fetch_idx;
    logic             fetch_ok;
    logic             unused_idx_hi;

    logic             mem_we;
    logic             mem_re;
    logic [IDX_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    assign clr_en = (state_q == ST_CLEAR);

    imem_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (clr_en),
        .cnt_o  (clr_cnt),
        .done_o (clr_done)
    );

    always_comb begin
        dec       = decode_fetch(DECODE_W'(pc_addr_i), DEPTH);
        fetch_idx = dec.idx[IDX_W-1:0];
        fetch_ok  = (state_q == ST_RUN) && fetch_en_i && !stall_i && !dec.fault;

        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_done)     state_d = ST_RUN;
            ST_RUN:   if (load_mode_i)  state_d = ST_LOAD;
            ST_LOAD:  if (!load_mode_i) state_d = ST_RUN;
            default:                    state_d = ST_CLEAR;
        endcase

        // Stall freezes the fetch result whatever state we are in.
        valid_d = valid_q;
        fault_d = fault_q;
        if (!stall_i) begin
            valid_d = fetch_ok;
            fault_d = (state_q == ST_RUN) && fetch_en_i && dec.fault;
        end

        ack_d   = (state_q == ST_LOAD) && load_we_i;
        ready_d = (state_d == ST_RUN);

        // One address port: the state decides who owns it this cycle.
        mem_we    = !rst_i && (clr_en || ack_d);
        mem_re    = fetch_ok;
        mem_wdata = clr_en ? NOP_WORD : load_data_i;
        case (state_q)
            ST_CLEAR: mem_addr = clr_cnt;
            ST_LOAD:  mem_addr = load_addr_i;
            default:  mem_addr = fetch_idx;
        endcase
    end

    assign unused_idx_hi = ^dec.idx[DECODE_W-1:IDX_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            ack_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            ack_q   <= ack_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_re) begin
            rd_data_q <= mem[mem_addr];
        end
    end

    // rd_data_q only advances on a good fetch, so it also holds through stalls.
    assign instr_o       = valid_q ? rd_data_q : NOP_WORD;
    assign instr_valid_o = valid_q;
    assign fault_o       = fault_q;
    assign load_ack_o    = ack_q;
    assign ready_o       = ready_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync: a spec-level model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_instr_mem_sync;

    localparam int DEPTH  = 64;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk_i;
    logic              rst_i;
    logic [ADDR_W-1:0] pc_addr_i;
    logic              fetch_en_i;
    logic              stall_i;
    logic [DATA_W-1:0] instr_o;
    logic              instr_valid_o;
    logic              fault_o;
    logic              load_mode_i;
    logic              load_we_i;
    logic [5:0]        load_addr_i;
    logic [DATA_W-1:0] load_data_i;
    logic              load_ack_o;
    logic              ready_o;

    int compared;
    int mismatched;

    instr_mem_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_addr_i     (pc_addr_i),
        .fetch_en_i    (fetch_en_i),
        .stall_i       (stall_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .fault_o       (fault_o),
        .load_mode_i   (load_mode_i),
        .load_we_i     (load_we_i),
        .load_addr_i   (load_addr_i),
        .load_data_i   (load_data_i),
        .load_ack_o    (load_ack_o),
        .ready_o       (ready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory contents plus "cycles of clear left" and "in load".
    logic [31:0] m_mem [DEPTH];
    bit          armed = 1'b0;
    int          clear_left;
    bit          in_load;
    logic [31:0] e_instr;
    bit          e_valid, e_fault, e_ack, e_ready;

    always @(posedge clk_i) begin
        bit running, loading;
        if (rst_i) begin
            armed      = 1'b1;
            clear_left = DEPTH;
            in_load    = 1'b0;
            e_instr    = 32'd0;
            e_valid    = 1'b0;
            e_fault    = 1'b0;
            e_ack      = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        end else if (armed) begin
            running = (clear_left == 0) && !in_load;
            loading = (clear_left == 0) && in_load;
            if (!stall_i) begin
                if (running && fetch_en_i) begin
                    e_fault = (pc_addr_i % 4 != 0) || (pc_addr_i / 4 >= DEPTH);
                    e_valid = !e_fault;
                    e_instr = e_fault ? 32'd0 : m_mem[pc_addr_i / 4];
                end else begin
                    e_fault = 1'b0;
                    e_valid = 1'b0;
                    e_instr = 32'd0;
                end
            end
            e_ack = loading && load_we_i;
            if (e_ack) m_mem[load_addr_i] = load_data_i;
            if (clear_left > 0)               clear_left--;
            else if (running && load_mode_i)  in_load = 1'b1;
            else if (loading && !load_mode_i) in_load = 1'b0;
        end
        e_ready = armed && (clear_left == 0) && !in_load;
        #1;
        if (armed) begin
            checkOutput("model_instr", instr_o, e_instr);
            checkOutput("model_valid", 32'(instr_valid_o), 32'(e_valid));
            checkOutput("model_fault", 32'(fault_o), 32'(e_fault));
            checkOutput("model_ack",   32'(load_ack_o), 32'(e_ack));
            checkOutput("model_ready", 32'(ready_o), 32'(e_ready));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic applyStimulus(input bit fetch, input logic [31:0] pc, input bit stall,
                                 input bit mode, input bit we, input logic [5:0] la,
                                 input logic [31:0] ld);
        fetch_en_i  = fetch;
        pc_addr_i   = pc;
        stall_i     = stall;
        load_mode_i = mode;
        load_we_i   = we;
        load_addr_i = la;
        load_data_i = ld;
        tick();
    endtask

    // Reset for one edge, then count how many samples ready_o stays low.
    task automatic runReset(input string name);
        int n;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checkOutput({name, "_rst_ready"}, 32'(ready_o), 32'd0);
        checkOutput({name, "_rst_valid"}, 32'(instr_valid_o), 32'd0);
        checkOutput({name, "_rst_instr"}, instr_o, 32'd0);
        n = 1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (ready_o) break;
            n++;
        end
        checkOutput({name, "_clear_len"}, n, DEPTH);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst_i       = 1'b0;
        fetch_en_i  = 1'b0;
        pc_addr_i   = '0;
        stall_i     = 1'b0;
        load_mode_i = 1'b0;
        load_we_i   = 1'b0;
        load_addr_i = '0;
        load_data_i = '0;

        runReset("boot");
        applyStimulus(1, 32'h0, 0, 0, 0, 6'd0, 32'd0);
        checkOutput("fetch0_instr", instr_o, 32'h0000_0000);
        checkOutput("fetch0_valid", 32'(instr_valid_o), 32'd1);

        applyStimulus(0, 32'h0, 0, 1, 0, 6'd0, 32'd0);
        checkOutput("enter_load_ready", 32'(ready_o), 32'd0);
        applyStimulus(0, 32'h0, 0, 1, 1, 6'd3, 32'h2001_0005);
        checkOutput("ack_w3", 32'(load_ack_o), 32'd1);
        applyStimulus(0, 32'h0, 0, 1, 1, 6'd4, 32'h8C22_0004);
        checkOutput("ack_w4", 32'(load_ack_o), 32'd1);
        applyStimulus(0, 32'h0, 0, 1, 0, 6'd0, 32'd0);
        checkOutput("ack_drop", 32'(load_ack_o), 32'd0);
        applyStimulus(0, 32'h0, 0, 0, 0, 6'd0, 32'd0);
        checkOutput("back_run_ready", 32'(ready_o), 32'd1);

        applyStimulus(1, 32'h0C, 0, 0, 0, 6'd0, 32'd0);
        checkOutput("fetch3_instr", instr_o, 32'h2001_0005);
        checkOutput("fetch3_valid", 32'(instr_valid_o), 32'd1);

        applyStimulus(1, 32'h0E, 0, 0, 0, 6'd0, 32'd0);
        checkOutput("misalign_fault", 32'(fault_o), 32'd1);
        checkOutput("misalign_valid", 32'(instr_valid_o), 32'd0);
        checkOutput("misalign_instr", instr_o, 32'd0);
        applyStimulus(1, 32'h100, 0, 0, 0, 6'd0, 32'd0);
        checkOutput("range_fault", 32'(fault_o), 32'd1);
        applyStimulus(1, 32'hFC, 0, 0, 0, 6'd0, 32'd0);
        checkOutput("last_word_fault", 32'(fault_o), 32'd0);

        applyStimulus(1, 32'h0C, 0, 0, 0, 6'd0, 32'd0);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1, 32'h10, 1, 0, 0, 6'd0, 32'd0);
            checkOutput("stall_hold", instr_o, 32'h2001_0005);
        end
        applyStimulus(1, 32'h10, 0, 0, 0, 6'd0, 32'd0);
        checkOutput("after_stall", instr_o, 32'h8C22_0004);

        applyStimulus(0, 32'h0, 0, 0, 1, 6'd5, 32'hDEAD_BEEF);
        checkOutput("run_we_noack", 32'(load_ack_o), 32'd0);
        applyStimulus(1, 32'h14, 0, 0, 0, 6'd0, 32'd0);
        checkOutput("run_we_word5", instr_o, 32'd0);
        checkOutput("run_we_valid", 32'(instr_valid_o), 32'd1);

        applyStimulus(0, 32'h0, 0, 1, 0, 6'd0, 32'd0);
        applyStimulus(0, 32'h0, 0, 1, 1, 6'd1, 32'h1111_1111);
        applyStimulus(0, 32'h0, 0, 1, 1, 6'd2, 32'h2222_2222);
        load_mode_i = 1'b0;
        load_we_i   = 1'b0;
        runReset("midload");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 32'(i * 4), 0, 0, 0, 6'd0, 32'd0);
            checkOutput("cleared_word", instr_o, 32'd0);
        end
        fetch_en_i = 1'b0;

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        runReset("midclear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
